// File: rtl/pc_gen_if.sv
// pc_gen_if: redirect-control and fetch-address bundle between branch/jump resolution and pc_gen
interface pc_gen_if #(parameter int XLEN = 32);
  logic            stall;
  logic [1:0]      pc_select;
  logic [XLEN-1:0] pc_in;
  logic            trap;
  logic            mret;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus_4;
  logic [XLEN-1:0] epc_out;
  logic            pc_valid;
  logic            misaligned;
  modport master (output stall, pc_select, pc_in, trap, mret,
                  input  pc_out, pc_plus_4, epc_out, pc_valid, misaligned);
  modport slave  (input  stall, pc_select, pc_in, trap, mret,
                  output pc_out, pc_plus_4, epc_out, pc_valid, misaligned);
endinterface

// File: rtl/pc_gen.sv
// pc_gen: program counter with branch/jump/trap/mret redirects and a post-reset boot wait.
// Define PC_MISALIGN_TRAP_EN to trap on misaligned branch/jump targets instead of masking them.
module pc_gen #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int              PC_STEP    = 4,
  parameter logic [XLEN-1:0] TRAP_VEC   = 32'h0000_0100,
  parameter int              BOOT_WAIT  = 2,
  parameter int              ALIGN_BITS = 2
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);
  localparam int CW = BOOT_WAIT > 0 ? $clog2(BOOT_WAIT + 1) : 1;
  localparam logic [XLEN-1:0] AMASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  typedef enum logic {BOOT, RUN} state_t;
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] pc_q, epc_q, pc_d, epc_d, tgt, nxt;
  logic            valid_q, mis_q, mis_d, redir, bad, go;
  always_comb begin
    redir = bus.pc_select == 2'b01 || bus.pc_select == 2'b10;
    tgt   = bus.pc_select == 2'b01 ? pc_q + bus.pc_in : bus.pc_in & ~XLEN'(1);
`ifdef PC_MISALIGN_TRAP_EN
    bad   = redir && (tgt & AMASK) != '0;
    nxt   = tgt;
`else
    bad   = 1'b0;
    nxt   = tgt & ~AMASK;
`endif
    go    = !bus.trap && !bus.stall && !bus.mret;
    pc_d  = bus.trap ? TRAP_VEC : bus.stall ? pc_q : bus.mret ? epc_q :
            redir ? (bad ? TRAP_VEC : nxt) : pc_q + XLEN'(PC_STEP);
    epc_d = (bus.trap || (go && bad)) ? pc_q : epc_q;
    mis_d = go && bad;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      cnt_q   <= '0;
      pc_q    <= BOOT_ADDR;
      epc_q   <= BOOT_ADDR;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else if (state_q == BOOT) begin
      mis_q <= 1'b0;
      if (cnt_q == CW'(BOOT_WAIT)) begin
        state_q <= RUN;
        valid_q <= 1'b1;
      end else cnt_q <= cnt_q + CW'(1);
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      mis_q <= mis_d;
    end
  end
  assign bus.pc_out     = pc_q;
  assign bus.pc_plus_4  = pc_q + XLEN'(PC_STEP);
  assign bus.epc_out    = epc_q;
  assign bus.pc_valid   = valid_q;
  assign bus.misaligned = mis_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: table-driven directed check of pc_gen, plus a mid-boot reset sequence.
module tb_pc_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  pc_gen_if #(.XLEN(32)) bus ();
  pc_gen dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic        rst, stall;
    logic [1:0]  sel;
    logic [31:0] pc_in;
    logic        trap, mret;
    logic [31:0] pc, epc;
    logic        valid, mis;
  } vec_t;
  vec_t vq[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic s, input logic [1:0] sel, input logic [31:0] pi,
                       input logic t, input logic m);
    @(negedge clk);
    rst = r; bus.stall = s; bus.pc_select = sel; bus.pc_in = pi; bus.trap = t; bus.mret = m;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.stall = 0; bus.pc_select = 0; bus.pc_in = 0; bus.trap = 0; bus.mret = 0;
    //          rst stl sel   pc_in         trp mrt pc                      epc                      v  mis
    vq.push_back('{1, 0, 2'd0, 32'h0,        0, 0, 32'h0,                  32'h0,                   0, 0});
    vq.push_back('{1, 0, 2'd0, 32'h0,        0, 0, 32'h0,                  32'h0,                   0, 0});
    vq.push_back('{0, 0, 2'd0, 32'h0,        1, 0, 32'h0,                  32'h0,                   0, 0});
    vq.push_back('{0, 0, 2'd1, 32'h80,       0, 0, 32'h0,                  32'h0,                   0, 0});
    vq.push_back('{0, 0, 2'd0, 32'h0,        0, 0, 32'h0,                  32'h0,                   1, 0});
    vq.push_back('{0, 0, 2'd0, 32'h0,        0, 0, 32'h4,                  32'h0,                   1, 0});
    vq.push_back('{0, 0, 2'd1, 32'h10,       0, 0, 32'h14,                 32'h0,                   1, 0});
    vq.push_back('{0, 0, 2'd3, 32'h0,        0, 0, 32'h18,                 32'h0,                   1, 0});
    vq.push_back('{0, 1, 2'd1, 32'h40,       0, 0, 32'h18,                 32'h0,                   1, 0});
    vq.push_back('{0, 0, 2'd1, 32'hFFFF_FFF8, 0, 0, 32'h10,                32'h0,                   1, 0});
    vq.push_back('{0, 0, 2'd2, 32'h203,      0, 0, MIS ? 32'h100 : 32'h200, MIS ? 32'h10 : 32'h0,  1, MIS});
    vq.push_back('{0, 0, 2'd0, 32'h0,        0, 0, MIS ? 32'h104 : 32'h204, MIS ? 32'h10 : 32'h0,  1, 0});
    vq.push_back('{0, 0, 2'd2, 32'h18,       0, 0, 32'h18,                 MIS ? 32'h10 : 32'h0,    1, 0});
    vq.push_back('{0, 1, 2'd0, 32'h0,        1, 0, 32'h100,                32'h18,                  1, 0});
    vq.push_back('{0, 0, 2'd0, 32'h0,        1, 1, 32'h100,                32'h100,                 1, 0});
    vq.push_back('{0, 0, 2'd1, 32'h8,        0, 1, 32'h100,                32'h100,                 1, 0});
    vq.push_back('{0, 0, 2'd0, 32'h0,        0, 0, 32'h104,                32'h100,                 1, 0});
    vq.push_back('{0, 0, 2'd0, 32'h0,        1, 0, 32'h100,                32'h104,                 1, 0});
    vq.push_back('{0, 0, 2'd2, 32'h3,        0, 1, 32'h104,                32'h104,                 1, 0});
    vq.push_back('{0, 1, 2'd0, 32'h0,        0, 1, 32'h104,                32'h104,                 1, 0});
    vq.push_back('{0, 0, 2'd2, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC,         32'h104,                 1, 0});
    vq.push_back('{0, 0, 2'd0, 32'h0,        0, 0, 32'h0,                  32'h104,                 1, 0});
    vq.push_back('{0, 0, 2'd1, 32'h42,       0, 0, MIS ? 32'h100 : 32'h40, MIS ? 32'h0 : 32'h104,   1, MIS});
    vq.push_back('{0, 0, 2'd2, 32'h40,       0, 0, 32'h40,                 MIS ? 32'h0 : 32'h104,   1, 0});
    vq.push_back('{1, 0, 2'd0, 32'h0,        1, 0, 32'h0,                  32'h0,                   0, 0});
    vq.push_back('{0, 0, 2'd0, 32'h0,        0, 0, 32'h0,                  32'h0,                   0, 0});
    vq.push_back('{0, 0, 2'd0, 32'h0,        0, 0, 32'h0,                  32'h0,                   0, 0});
    vq.push_back('{0, 0, 2'd0, 32'h0,        0, 0, 32'h0,                  32'h0,                   1, 0});
    vq.push_back('{0, 0, 2'd0, 32'h0,        0, 0, 32'h4,                  32'h0,                   1, 0});
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].stall, vq[i].sel, vq[i].pc_in, vq[i].trap, vq[i].mret);
      chk($sformatf("v%0d.pc_out", i), bus.pc_out, vq[i].pc);
      chk($sformatf("v%0d.epc_out", i), bus.epc_out, vq[i].epc);
      chk($sformatf("v%0d.pc_valid", i), 32'(bus.pc_valid), 32'(vq[i].valid));
      chk($sformatf("v%0d.misaligned", i), 32'(bus.misaligned), 32'(vq[i].mis));
      chk($sformatf("v%0d.pc_plus_4", i), bus.pc_plus_4, vq[i].pc + 32'd4);
    end
    // reset pulsed mid-boot must restart the wait count from zero
    drive(1, 0, 2'd0, 0, 0, 0);
    drive(0, 0, 2'd0, 0, 0, 0);
    drive(0, 0, 2'd0, 0, 0, 0);
    chk("midboot.valid_before", 32'(bus.pc_valid), 32'd0);
    drive(1, 0, 2'd0, 0, 0, 0);
    begin
      int edges = 0;
      while (!bus.pc_valid && edges < 10) begin
        drive(0, 0, 2'd0, 0, 1, 0);
        edges++;
      end
      chk("midboot.edges_to_valid", 32'(edges), 32'd3);
      chk("midboot.pc_out", bus.pc_out, 32'h0);
      chk("midboot.epc_out", bus.epc_out, 32'h0);
    end
    drive(0, 0, 2'd0, 0, 0, 0);
    chk("midboot.first_step", bus.pc_out, 32'h4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
